// File: rtl/nclic_pkg.sv
// nclic_pkg: types and constants shared by the n_clic tree, the preemption
// controller and their benches.
//   IntIndex    - interrupt source id (INT_AMOUNT sources)
//   IntPriority - interrupt priority (PRIORITIES values)
//   IntLevel    - running level: 0 = thread, priority p runs at level p+1
//   ctrl_state_e - request/commit state of the preemption controller
package nclic_pkg;

    localparam int INT_AMOUNT = 8;
    localparam int PRIORITIES = 4;

    typedef logic [$clog2(INT_AMOUNT)-1:0] IntIndex;
    typedef logic [$clog2(PRIORITIES)-1:0] IntPriority;
    typedef logic [$clog2(PRIORITIES):0]   IntLevel;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_COMMIT = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/nclic_level_stack.sv
// nclic_level_stack: LIFO of running levels saved on interrupt entry.
//   clk, reset - clock, synchronous active-low reset
//   push_i     - store data_i on top
//   pop_i      - discard the top entry (caller guarantees depth_o > 0)
//   push_i & pop_i together replace the top entry with data_i
//   data_i     - level to push
//   top_o      - current top entry (0 when empty)
//   depth_o    - number of stored entries
module nclic_level_stack #(
    parameter int DEPTH = nclic_pkg::PRIORITIES,
    parameter int WIDTH = $bits(nclic_pkg::IntLevel)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [WIDTH-1:0]             data_i,
    output logic [WIDTH-1:0]             top_o,
    output logic [$clog2(DEPTH+1)-1:0]   depth_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0] depth_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            depth_q <= '0;
            // NOTE: the entries are few and must read back as zero after reset,
            // so the storage is reset like ordinary flops rather than left as RAM.
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push_i && !pop_i) begin
                depth_q <= depth_q + CNT_W'(1);
                for (int i = 0; i < DEPTH; i++)
                    if (depth_q == CNT_W'(i)) mem_q[i] <= data_i;
            end else if (pop_i && !push_i) begin
                depth_q <= depth_q - CNT_W'(1);
            end else if (push_i && pop_i) begin
                for (int i = 0; i < DEPTH; i++)
                    if (depth_q == CNT_W'(i + 1)) mem_q[i] <= data_i;
            end
        end
    end

    always_comb begin
        top_o = '0;
        for (int i = 0; i < DEPTH; i++)
            if (depth_q == CNT_W'(i + 1)) top_o = mem_q[i];
    end

    assign depth_o = depth_q;

    // Levels strictly increase on every push, so the stack can never overflow,
    // and the controller only pops a non-empty stack.
    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!(push_i && !pop_i && depth_q == CNT_W'(DEPTH)));
            assert (!(pop_i && depth_q == '0));
        end
    end

endmodule

// File: rtl/nclic_preempt_ctrl.sv
// nclic_preempt_ctrl: applies the running-level threshold to the n_clic tree
// winner and offers it to the core through a req/ack handshake.
//   clk, reset            - clock, synchronous active-low reset
//   i_int/i_idx/i_prio    - combinational tree winner
//   o_req/o_vec_idx/o_vec_prio - stable request offered to the core
//   i_ack                 - core takes the offered interrupt
//   i_ret                 - core returns from an interrupt (pops a level)
//   o_clr/o_clr_idx       - one-cycle pending-bit clear for the taken id
//   o_level/o_depth       - running level and nesting depth
//   o_err                 - sticky: return underflow or ack without request
module nclic_preempt_ctrl #(
    parameter type IntIndex    = nclic_pkg::IntIndex,
    parameter type IntPriority = nclic_pkg::IntPriority,
    parameter int  PRIORITIES  = nclic_pkg::PRIORITIES
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              i_int,
    input  IntIndex                           i_idx,
    input  IntPriority                        i_prio,
    output logic                              o_req,
    output IntIndex                           o_vec_idx,
    output IntPriority                        o_vec_prio,
    input  logic                              i_ack,
    input  logic                              i_ret,
    output logic                              o_clr,
    output IntIndex                           o_clr_idx,
    output logic [$clog2(PRIORITIES):0]       o_level,
    output logic [$clog2(PRIORITIES+1)-1:0]   o_depth,
    output logic                              o_err
);

    import nclic_pkg::*;

    localparam int LVL_W = $clog2(PRIORITIES) + 1;
    localparam int DEP_W = $clog2(PRIORITIES + 1);

    ctrl_state_e       state_q, state_d;
    IntIndex           vec_idx_q, vec_idx_d;
    IntPriority        vec_prio_q, vec_prio_d;
    logic              clr_q, clr_d;
    IntIndex           clr_idx_q, clr_idx_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              err_q, err_d;

    logic              push, pop;
    logic [LVL_W-1:0]  push_data;
    logic [LVL_W-1:0]  stack_top;
    logic [DEP_W-1:0]  depth;
    logic              eligible;
    logic              ret_ok;

    // Priority p runs at level p+1, so it preempts only when p+1 exceeds the
    // running level; compare at level width so p+1 cannot wrap.
    assign eligible = i_int && ((LVL_W'(i_prio) + LVL_W'(1)) > level_q);
    assign ret_ok   = i_ret && (depth != '0);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch
        // can leave one unassigned and infer a latch.
        state_d    = state_q;
        vec_idx_d  = vec_idx_q;
        vec_prio_d = vec_prio_q;
        clr_d      = 1'b0;
        clr_idx_d  = clr_idx_q;
        level_d    = level_q;
        err_d      = err_q;
        push       = 1'b0;
        pop        = 1'b0;
        push_data  = level_q;

        if (i_ret && !ret_ok) err_d = 1'b1;
        if (i_ack && state_q != ST_REQ) err_d = 1'b1;

        if (ret_ok) begin
            pop     = 1'b1;
            level_d = stack_top;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (eligible) begin
                    vec_idx_d  = i_idx;
                    vec_prio_d = i_prio;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_ack) begin
                    // Tail-chain: the popped level is pushed straight back, so
                    // the stack top and depth are left as they were.
                    push      = 1'b1;
                    push_data = ret_ok ? stack_top : level_q;
                    level_d   = LVL_W'(vec_prio_q) + LVL_W'(1);
                    clr_d     = 1'b1;
                    clr_idx_d = vec_idx_q;
                    state_d   = ST_COMMIT;
                end else if (!eligible) begin
                    state_d = ST_IDLE;
                end else if (i_prio > vec_prio_q) begin
                    vec_idx_d  = i_idx;
                    vec_prio_d = i_prio;
                end
            end
            // The tree still shows the taken source this cycle because its
            // pending bit clears only after o_clr; hold off one cycle.
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            vec_idx_q  <= '0;
            vec_prio_q <= '0;
            clr_q      <= 1'b0;
            clr_idx_q  <= '0;
            level_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q    <= state_d;
            vec_idx_q  <= vec_idx_d;
            vec_prio_q <= vec_prio_d;
            clr_q      <= clr_d;
            clr_idx_q  <= clr_idx_d;
            level_q    <= level_d;
            err_q      <= err_d;
        end
    end

    nclic_level_stack #(
        .DEPTH (PRIORITIES),
        .WIDTH (LVL_W)
    ) u_stack (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (push_data),
        .top_o   (stack_top),
        .depth_o (depth)
    );

    assign o_req      = (state_q == ST_REQ);
    assign o_vec_idx  = vec_idx_q;
    assign o_vec_prio = vec_prio_q;
    assign o_clr      = clr_q;
    assign o_clr_idx  = clr_idx_q;
    assign o_level    = level_q;
    assign o_depth    = depth;
    assign o_err      = err_q;

endmodule

// File: tb/tb_nclic_preempt_ctrl.sv
module tb_nclic_preempt_ctrl;
    import nclic_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_int;
    IntIndex    i_idx;
    IntPriority i_prio;
    logic       o_req;
    IntIndex    o_vec_idx;
    IntPriority o_vec_prio;
    logic       i_ack;
    logic       i_ret;
    logic       o_clr;
    IntIndex    o_clr_idx;
    logic [2:0] o_level;
    logic [2:0] o_depth;
    logic       o_err;

    int total = 0;
    int bad   = 0;

    nclic_preempt_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .i_int      (i_int),
        .i_idx      (i_idx),
        .i_prio     (i_prio),
        .o_req      (o_req),
        .o_vec_idx  (o_vec_idx),
        .o_vec_prio (o_vec_prio),
        .i_ack      (i_ack),
        .i_ret      (i_ret),
        .o_clr      (o_clr),
        .o_clr_idx  (o_clr_idx),
        .o_level    (o_level),
        .o_depth    (o_depth),
        .o_err      (o_err)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; outputs are sampled and inputs changed 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        i_int = 1'b0; i_idx = '0; i_prio = '0; i_ack = 1'b0; i_ret = 1'b0;
        tick(); tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        i_int = 1'b1; i_idx = IntIndex'(INT_AMOUNT - 3); i_prio = 2'd2;
        i_ack = 1'b0; i_ret = 1'b0;
        tick(); tick(); tick();
        total++;
        if ({o_req, o_vec_idx, o_vec_prio, o_clr, o_clr_idx, o_level, o_depth, o_err} !== 17'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {o_req, o_vec_idx, o_vec_prio, o_clr, o_clr_idx, o_level, o_depth, o_err});
        end
        reset = 1'b1;
        #2;
        total++;
        if (o_req !== 1'b0) begin
            bad++; $display("FAIL reset_release_req: got %b expected 0", o_req);
        end
        tick();
        total++;
        if (o_req !== 1'b1 || o_vec_idx !== 3'd5) begin
            bad++; $display("FAIL reset_first_req: got req=%b idx=%0d expected req=1 idx=5", o_req, o_vec_idx);
        end
    endtask

    task automatic test_single_take();
        do_reset();
        i_int = 1'b1; i_idx = 3'd5; i_prio = 2'd2;
        tick();
        total++;
        if (o_req !== 1'b1 || o_vec_idx !== 3'd5 || o_vec_prio !== 2'd2) begin
            bad++; $display("FAIL take_req: got req=%b idx=%0d prio=%0d expected 1/5/2", o_req, o_vec_idx, o_vec_prio);
        end
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
        total++;
        if (o_level !== 3'd3 || o_depth !== 3'd1) begin
            bad++; $display("FAIL take_level: got level=%0d depth=%0d expected 3/1", o_level, o_depth);
        end
        total++;
        if (o_clr !== 1'b1 || o_clr_idx !== 3'd5 || o_req !== 1'b0) begin
            bad++; $display("FAIL take_clr: got clr=%b idx=%0d req=%b expected 1/5/0", o_clr, o_clr_idx, o_req);
        end
        tick();
        total++;
        if (o_clr !== 1'b0 || o_req !== 1'b0 || o_err !== 1'b0) begin
            bad++; $display("FAIL take_commit: got clr=%b req=%b err=%b expected 0/0/0", o_clr, o_req, o_err);
        end
    endtask

    // Continues from level 3 left by test_single_take.
    task automatic test_threshold();
        i_int = 1'b1; i_idx = 3'd1; i_prio = 2'd1;
        tick();
        total++;
        if (o_req !== 1'b0) begin
            bad++; $display("FAIL thresh_prio1: got req=%b expected 0", o_req);
        end
        i_prio = 2'd2;
        tick();
        total++;
        if (o_req !== 1'b0) begin
            bad++; $display("FAIL thresh_prio2: got req=%b expected 0", o_req);
        end
        i_idx = 3'd2; i_prio = 2'd3;
        tick();
        total++;
        if (o_req !== 1'b1 || o_vec_idx !== 3'd2) begin
            bad++; $display("FAIL thresh_prio3: got req=%b idx=%0d expected 1/2", o_req, o_vec_idx);
        end
        i_int = 1'b0;
        tick();
    endtask

    task automatic test_retarget_withdraw();
        do_reset();
        i_int = 1'b1; i_idx = 3'd6; i_prio = 2'd1;
        tick();
        total++;
        if (o_req !== 1'b1 || o_vec_idx !== 3'd6) begin
            bad++; $display("FAIL retarget_first: got req=%b idx=%0d expected 1/6", o_req, o_vec_idx);
        end
        i_idx = 3'd2; i_prio = 2'd3;
        tick();
        total++;
        if (o_req !== 1'b1 || o_vec_idx !== 3'd2 || o_vec_prio !== 2'd3) begin
            bad++; $display("FAIL retarget_new: got req=%b idx=%0d prio=%0d expected 1/2/3", o_req, o_vec_idx, o_vec_prio);
        end
        i_idx = 3'd4; i_prio = 2'd2;
        tick();
        total++;
        if (o_vec_idx !== 3'd2 || o_vec_prio !== 2'd3) begin
            bad++; $display("FAIL retarget_lower_ignored: got idx=%0d prio=%0d expected 2/3", o_vec_idx, o_vec_prio);
        end
        i_int = 1'b0;
        tick();
        total++;
        if (o_req !== 1'b0 || o_err !== 1'b0 || o_depth !== 3'd0) begin
            bad++; $display("FAIL withdraw: got req=%b err=%b depth=%0d expected 0/0/0", o_req, o_err, o_depth);
        end
    endtask

    task automatic test_nest_unwind();
        do_reset();
        i_int = 1'b1; i_idx = 3'd1; i_prio = 2'd1;
        tick();
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
        total++;
        if (o_level !== 3'd2 || o_depth !== 3'd1) begin
            bad++; $display("FAIL nest_first: got level=%0d depth=%0d expected 2/1", o_level, o_depth);
        end
        i_idx = 3'd3; i_prio = 2'd3;
        tick();
        total++;
        if (o_req !== 1'b0) begin
            bad++; $display("FAIL nest_commit_mask: got req=%b expected 0", o_req);
        end
        tick();
        total++;
        if (o_req !== 1'b1 || o_vec_idx !== 3'd3) begin
            bad++; $display("FAIL nest_second_req: got req=%b idx=%0d expected 1/3", o_req, o_vec_idx);
        end
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0; i_int = 1'b0;
        total++;
        if (o_level !== 3'd4 || o_depth !== 3'd2) begin
            bad++; $display("FAIL nest_second: got level=%0d depth=%0d expected 4/2", o_level, o_depth);
        end
        tick();
        i_ret = 1'b1;
        tick();
        total++;
        if (o_level !== 3'd2 || o_depth !== 3'd1) begin
            bad++; $display("FAIL unwind_1: got level=%0d depth=%0d expected 2/1", o_level, o_depth);
        end
        tick();
        total++;
        if (o_level !== 3'd0 || o_depth !== 3'd0 || o_err !== 1'b0) begin
            bad++; $display("FAIL unwind_2: got level=%0d depth=%0d err=%b expected 0/0/0", o_level, o_depth, o_err);
        end
        tick();
        i_ret = 1'b0;
        total++;
        if (o_err !== 1'b1 || o_depth !== 3'd0 || o_level !== 3'd0) begin
            bad++; $display("FAIL unwind_underflow: got err=%b depth=%0d level=%0d expected 1/0/0", o_err, o_depth, o_level);
        end
    endtask

    task automatic test_tail_chain();
        do_reset();
        i_int = 1'b1; i_idx = 3'd4; i_prio = 2'd1;
        tick();
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
        i_idx = 3'd7; i_prio = 2'd2;
        tick();
        tick();
        total++;
        if (o_req !== 1'b1 || o_vec_idx !== 3'd7 || o_level !== 3'd2 || o_depth !== 3'd1) begin
            bad++; $display("FAIL tail_setup: got req=%b idx=%0d level=%0d depth=%0d expected 1/7/2/1",
                            o_req, o_vec_idx, o_level, o_depth);
        end
        i_ack = 1'b1; i_ret = 1'b1;
        tick();
        i_ack = 1'b0; i_ret = 1'b0; i_int = 1'b0;
        total++;
        if (o_level !== 3'd3 || o_depth !== 3'd1 || o_clr !== 1'b1 || o_clr_idx !== 3'd7 || o_err !== 1'b0) begin
            bad++; $display("FAIL tail_chain: got level=%0d depth=%0d clr=%b idx=%0d err=%b expected 3/1/1/7/0",
                            o_level, o_depth, o_clr, o_clr_idx, o_err);
        end
        tick();
        i_ret = 1'b1;
        tick();
        i_ret = 1'b0;
        total++;
        if (o_level !== 3'd0 || o_depth !== 3'd0) begin
            bad++; $display("FAIL tail_stack_top: got level=%0d depth=%0d expected 0/0", o_level, o_depth);
        end
        // Ret restores level at t+1; a lower-priority source raises o_req at t+2.
        i_int = 1'b1; i_idx = 3'd1; i_prio = 2'd0;
        tick();
        total++;
        if (o_req !== 1'b1 || o_vec_idx !== 3'd1) begin
            bad++; $display("FAIL ret_then_req: got req=%b idx=%0d expected 1/1", o_req, o_vec_idx);
        end
    endtask

    task automatic test_reset_mid_flight();
        do_reset();
        i_int = 1'b1; i_idx = 3'd5; i_prio = 2'd2;
        tick();
        i_ack = 1'b1; reset = 1'b0;
        tick();
        i_ack = 1'b0; reset = 1'b1; i_int = 1'b0;
        total++;
        if (o_clr !== 1'b0 || o_req !== 1'b0 || o_level !== 3'd0 || o_depth !== 3'd0 || o_err !== 1'b0) begin
            bad++; $display("FAIL reset_mid_req: got clr=%b req=%b level=%0d depth=%0d err=%b expected all 0",
                            o_clr, o_req, o_level, o_depth, o_err);
        end
        i_int = 1'b1;
        tick();
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0; reset = 1'b0;
        tick();
        reset = 1'b1; i_int = 1'b0;
        total++;
        if (o_clr !== 1'b0 || o_clr_idx !== 3'd0 || o_level !== 3'd0 || o_depth !== 3'd0) begin
            bad++; $display("FAIL reset_mid_commit: got clr=%b idx=%0d level=%0d depth=%0d expected all 0",
                            o_clr, o_clr_idx, o_level, o_depth);
        end
    endtask

    task automatic test_illegal_ack();
        do_reset();
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
        total++;
        if (o_err !== 1'b1 || o_clr !== 1'b0 || o_depth !== 3'd0) begin
            bad++; $display("FAIL illegal_ack: got err=%b clr=%b depth=%0d expected 1/0/0", o_err, o_clr, o_depth);
        end
        tick();
        total++;
        if (o_err !== 1'b1) begin
            bad++; $display("FAIL err_sticky: got err=%b expected 1", o_err);
        end
    endtask

    initial begin
        test_reset();
        test_single_take();
        test_threshold();
        test_retarget_withdraw();
        test_nest_unwind();
        test_tail_chain();
        test_reset_mid_flight();
        test_illegal_ack();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
